// File: rtl/interrupt_arbiter_pkg.sv
// rtl/interrupt_arbiter_pkg.sv - shared FSM encodings and requester indices for the interrupt arbiter
package interrupt_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_ISSUE = 3'b010,
      ST_GAP   = 3'b100
   } arb_state_t;

   localparam int REQ_RX        = 0;
   localparam int REQ_TX        = 1;
   localparam int GAP_W_DEFAULT = 16;

endpackage

// File: rtl/interrupt_gap_timer.sv
// rtl/interrupt_gap_timer.sv - down-counter that holds the arbiter in GAP for load_val+1 counting cycles
module interrupt_gap_timer #(
   parameter int GAP_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [GAP_W-1:0] load_val,
   input  logic             count,
   output logic             done
);

   logic [GAP_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (count && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // done fires on the counting cycle that sees zero, so a zero load still yields one cycle
   assign done = count && (r_cnt == '0);

endmodule

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - round-robin arbiter merging Rx/Tx interrupt requests onto one core interrupt
module interrupt_arbiter
   import interrupt_arbiter_pkg::*;
#(
   parameter int GAP_W = GAP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_interrupt_n,
   output logic             rx_interrupt_rdy_n,
   input  logic             tx_interrupt_n,
   output logic             tx_interrupt_rdy_n,
   output logic             cfg_interrupt_n,
   input  logic             cfg_interrupt_rdy_n,
   input  logic [GAP_W-1:0] min_gap,
   output logic             grant_tx,
   output logic             busy,
   output logic [31:0]      interrupt_count
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic        r_cfg_int_n;
   logic        r_rx_rdy_n;
   logic        r_tx_rdy_n;
   logic        r_grant_tx;
   logic        r_last_tx;
   logic        r_busy;
   logic [31:0] r_int_count;

   logic w_cfg_int_n_nxt;
   logic w_rx_rdy_n_nxt;
   logic w_tx_rdy_n_nxt;
   logic w_grant_tx_nxt;
   logic w_last_tx_nxt;
   logic w_accept;
   logic w_gap_done;
   logic w_rx_req;
   logic w_tx_req;

   assign w_rx_req = ~rx_interrupt_n;
   assign w_tx_req = ~tx_interrupt_n;

   always_comb begin
      w_state_nxt     = r_state;
      w_cfg_int_n_nxt = r_cfg_int_n;
      w_rx_rdy_n_nxt  = 1'b1;
      w_tx_rdy_n_nxt  = 1'b1;
      w_grant_tx_nxt  = r_grant_tx;
      w_last_tx_nxt   = r_last_tx;
      w_accept        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rx_req || w_tx_req) begin
               // on a tie, Tx wins only when Rx was served last
               w_grant_tx_nxt  = w_tx_req && (!w_rx_req || !r_last_tx);
               w_cfg_int_n_nxt = 1'b0;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!cfg_interrupt_rdy_n) begin
               w_accept        = 1'b1;
               w_cfg_int_n_nxt = 1'b1;
               w_rx_rdy_n_nxt  = r_grant_tx;
               w_tx_rdy_n_nxt  = ~r_grant_tx;
               w_last_tx_nxt   = r_grant_tx;
               w_state_nxt     = ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_gap_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_cfg_int_n_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cfg_int_n <= 1'b1;
         r_rx_rdy_n  <= 1'b1;
         r_tx_rdy_n  <= 1'b1;
         r_grant_tx  <= 1'b0;
         r_last_tx   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cfg_int_n <= w_cfg_int_n_nxt;
         r_rx_rdy_n  <= w_rx_rdy_n_nxt;
         r_tx_rdy_n  <= w_tx_rdy_n_nxt;
         r_grant_tx  <= w_grant_tx_nxt;
         r_last_tx   <= w_last_tx_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int_count <= '0;
      end else if (w_accept) begin
         r_int_count <= r_int_count + 32'd1;
      end
   end

   interrupt_gap_timer #(
      .GAP_W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_accept),
      .load_val (min_gap),
      .count    (r_state == ST_GAP),
      .done     (w_gap_done)
   );

   assign cfg_interrupt_n    = r_cfg_int_n;
   assign rx_interrupt_rdy_n = r_rx_rdy_n;
   assign tx_interrupt_rdy_n = r_tx_rdy_n;
   assign grant_tx           = r_grant_tx;
   assign busy               = r_busy;
   assign interrupt_count    = r_int_count;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - scoreboard bench for the interrupt arbiter
module tb_interrupt_arbiter;

   logic        clk;
   logic        reset;
   logic        rx_interrupt_n;
   logic        rx_interrupt_rdy_n;
   logic        tx_interrupt_n;
   logic        tx_interrupt_rdy_n;
   logic        cfg_interrupt_n;
   logic        cfg_interrupt_rdy_n;
   logic [15:0] min_gap;
   logic        grant_tx;
   logic        busy;
   logic [31:0] interrupt_count;

   typedef struct packed {
      logic        tx;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_rdy_low = 1'b0;

   interrupt_arbiter #(
      .GAP_W (16)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .rx_interrupt_n      (rx_interrupt_n),
      .rx_interrupt_rdy_n  (rx_interrupt_rdy_n),
      .tx_interrupt_n      (tx_interrupt_n),
      .tx_interrupt_rdy_n  (tx_interrupt_rdy_n),
      .cfg_interrupt_n     (cfg_interrupt_n),
      .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
      .min_gap             (min_gap),
      .grant_tx            (grant_tx),
      .busy                (busy),
      .interrupt_count     (interrupt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cfg(input logic lvl, input string name, output int n);
      n = 0;
      while (cfg_interrupt_n !== lvl && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, cfg_interrupt_n=%b expected %b", name, cfg_interrupt_n, lvl);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, busy=%b expected 0", name, busy);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_cfg_n", cfg_interrupt_n, 1);
      check("rst_rx_rdy_n", rx_interrupt_rdy_n, 1);
      check("rst_tx_rdy_n", tx_interrupt_rdy_n, 1);
      check("rst_busy", busy, 0);
      check("rst_grant_tx", grant_tx, 0);
      check("rst_count", interrupt_count, 0);
   endtask

   // monitor: protocol invariants every cycle, scoreboard pop on each completion pulse
   always @(negedge clk) begin
      exp_t e;
      checks++;
      assert (rx_interrupt_rdy_n || tx_interrupt_rdy_n) else begin
         errors++;
         $display("FAIL rdy_overlap: rx_rdy_n=%b tx_rdy_n=%b, both low", rx_interrupt_rdy_n, tx_interrupt_rdy_n);
      end
      checks++;
      assert (cfg_interrupt_n || (rx_interrupt_rdy_n && tx_interrupt_rdy_n)) else begin
         errors++;
         $display("FAIL rdy_during_cfg: cfg_n=%b rx_rdy_n=%b tx_rdy_n=%b", cfg_interrupt_n, rx_interrupt_rdy_n, tx_interrupt_rdy_n);
      end
      if (!rx_interrupt_rdy_n || !tx_interrupt_rdy_n) begin
         if (prev_rdy_low) begin
            checks++;
            errors++;
            $display("FAIL rdy_width: rdy_n low for more than one cycle");
         end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: rdy pulse rx=%b tx=%b with no expected completion", rx_interrupt_rdy_n, tx_interrupt_rdy_n);
         end else begin
            e = sb_q.pop_front();
            check("sb_side_tx", {31'b0, !tx_interrupt_rdy_n}, {31'b0, e.tx});
            check("sb_grant_tx", {31'b0, grant_tx}, {31'b0, e.tx});
            check("sb_count", interrupt_count, e.cnt);
         end
      end
      prev_rdy_low = !rx_interrupt_rdy_n || !tx_interrupt_rdy_n;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c_high;
      int c_gap;
      reset               = 1'b1;
      rx_interrupt_n      = 1'b1;
      tx_interrupt_n      = 1'b1;
      cfg_interrupt_rdy_n = 1'b1;
      min_gap             = 16'd2;

      // Rx only, core accepts after cfg_interrupt_n has been low 4 cycles
      do_reset();
      sb_q.push_back('{tx: 1'b0, cnt: 32'd1});
      rx_interrupt_n = 1'b0;
      wait_cfg(1'b0, "t1_req", n);
      check("t1_latency", n, 1);
      check("t1_grant_tx", grant_tx, 0);
      check("t1_busy", busy, 1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("t1_cfg_hold", cfg_interrupt_n, 0);
      end
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      rx_interrupt_n      = 1'b1;
      check("t1_cfg_release", cfg_interrupt_n, 1);
      check("t1_count", interrupt_count, 1);
      @(negedge clk);
      check("t1_rdy_pulse_end", rx_interrupt_rdy_n, 1);
      wait_idle("t1_idle");

      // simultaneous requests from reset: Tx first, Rx after the gap
      do_reset();
      sb_q.push_back('{tx: 1'b1, cnt: 32'd1});
      sb_q.push_back('{tx: 1'b0, cnt: 32'd2});
      rx_interrupt_n = 1'b0;
      tx_interrupt_n = 1'b0;
      wait_cfg(1'b0, "t2_first", n);
      check("t2_latency", n, 1);
      check("t2_grant_first", grant_tx, 1);
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      tx_interrupt_n      = 1'b1;
      check("t2_cfg_release", cfg_interrupt_n, 1);
      wait_cfg(1'b0, "t2_second", n);
      check("t2_gap_wait", n, 4);
      check("t2_grant_second", grant_tx, 0);
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      rx_interrupt_n      = 1'b1;
      check("t2_count", interrupt_count, 2);
      wait_idle("t2_idle");

      // min_gap=5 with Tx held; min_gap cleared mid-GAP must not shorten it
      do_reset();
      sb_q.push_back('{tx: 1'b1, cnt: 32'd1});
      sb_q.push_back('{tx: 1'b1, cnt: 32'd2});
      min_gap        = 16'd5;
      tx_interrupt_n = 1'b0;
      wait_cfg(1'b0, "t3_first", n);
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      c_high = 0;
      c_gap  = 0;
      for (int i = 0; i < 40 && cfg_interrupt_n; i++) begin
         c_high++;
         if (busy) c_gap++;
         if (c_high == 2) min_gap = 16'd0;
         @(negedge clk);
      end
      check("t3_gap_cycles", c_gap, 6);
      check("t3_cfg_high_cycles", c_high, 7);
      check("t3_grant_second", grant_tx, 1);
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      tx_interrupt_n      = 1'b1;
      wait_idle("t3_idle");

      // asynchronous reset in the middle of ISSUE
      rx_interrupt_n = 1'b0;
      wait_cfg(1'b0, "t4_req", n);
      check("t4_busy_before", busy, 1);
      #1 reset = 1'b1;
      #1;
      check("t4_cfg_n", cfg_interrupt_n, 1);
      check("t4_busy", busy, 0);
      check("t4_count", interrupt_count, 0);
      check("t4_grant_tx", grant_tx, 0);
      check("t4_rx_rdy_n", rx_interrupt_rdy_n, 1);
      rx_interrupt_n = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // interrupt_count wraps from all-ones to zero
      force dut.r_int_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_int_count;
      sb_q.push_back('{tx: 1'b0, cnt: 32'd0});
      rx_interrupt_n = 1'b0;
      wait_cfg(1'b0, "t5_req", n);
      cfg_interrupt_rdy_n = 1'b0;
      @(negedge clk);
      cfg_interrupt_rdy_n = 1'b1;
      rx_interrupt_n      = 1'b1;
      check("t5_wrap", interrupt_count, 0);
      wait_idle("t5_idle");

      @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
